// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard query bundle between the decode stage and the hazard scoreboard.
// The master drives the decoded instruction fields and flush; the scoreboard answers with stall/forward controls.
interface hazard_scoreboard_if #(
  parameter int NSTAGE = 3,
  parameter int CNT_W  = 16
);
  localparam int SEL_W = $clog2(NSTAGE + 1);

  logic             d_valid;
  logic [4:0]       d_rs;
  logic [4:0]       d_rt;
  logic [1:0]       d_tuse_rs;
  logic [1:0]       d_tuse_rt;
  logic             d_use_rs;
  logic             d_use_rt;
  logic             d_wr_en;
  logic [4:0]       d_wr_addr;
  logic [1:0]       d_tnew;
  logic [1:0]       d_md_op;
  logic             d_eret;
  logic             d_mtc0_epc;
  logic             flush;

  logic             stall;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_clr;
  logic [SEL_W-1:0] fwd_rs_sel;
  logic [SEL_W-1:0] fwd_rt_sel;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_use_rs, d_use_rt,
           d_wr_en, d_wr_addr, d_tnew, d_md_op, d_eret, d_mtc0_epc, flush,
    input  stall, pc_en, ifid_en, idex_clr, fwd_rs_sel, fwd_rt_sel, md_busy, stall_cnt
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_use_rs, d_use_rt,
           d_wr_en, d_wr_addr, d_tnew, d_md_op, d_eret, d_mtc0_epc, flush,
    output stall, pc_en, ifid_en, idex_clr, fwd_rs_sel, fwd_rt_sel, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard: tracks in-flight writers after D, raises data/MDU/EPC stalls
// and picks the forwarding source for each D-stage operand.
module hazard_scoreboard #(
  parameter int NSTAGE   = 3,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave sb
);
  localparam int SEL_W  = $clog2(NSTAGE + 1);
  localparam int MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int MD_W   = (MD_MAX < 2) ? 1 : $clog2(MD_MAX + 1);

  typedef struct packed {
    logic       v;
    logic [4:0] addr;
    logic [1:0] tnew;
    logic       epc;
  } ent_t;

  ent_t             ent [NSTAGE];
  logic             md_mark;
  logic [MD_W-1:0]  md_cnt;
  logic [CNT_W-1:0] stall_cnt;

  logic             stall_rs, stall_rt, epc_hit, hit_rs, hit_rt;
  logic [SEL_W-1:0] fwd_rs, fwd_rt;
  logic             mdu_stall, stall, issue, md_start, load0;

  // Scan youngest-first so the first address match decides forwarding.
  always_comb begin
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    epc_hit  = 1'b0;
    hit_rs   = 1'b0;
    hit_rt   = 1'b0;
    fwd_rs   = '0;
    fwd_rt   = '0;
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      if (ent[i].v) begin
        if (ent[i].epc)
          epc_hit = 1'b1;
        if (sb.d_rs != '0 && ent[i].addr == sb.d_rs) begin
          if (sb.d_use_rs && sb.d_tuse_rs < ent[i].tnew)
            stall_rs = 1'b1;
          if (!hit_rs) begin
            hit_rs = 1'b1;
            if (ent[i].tnew == '0)
              fwd_rs = SEL_W'(i + 1);
          end
        end
        if (sb.d_rt != '0 && ent[i].addr == sb.d_rt) begin
          if (sb.d_use_rt && sb.d_tuse_rt < ent[i].tnew)
            stall_rt = 1'b1;
          if (!hit_rt) begin
            hit_rt = 1'b1;
            if (ent[i].tnew == '0)
              fwd_rt = SEL_W'(i + 1);
          end
        end
      end
    end
  end

  assign mdu_stall = (sb.d_md_op != 2'd0) && ((md_cnt != '0) || md_mark);
  assign stall     = sb.d_valid & (stall_rs | stall_rt | mdu_stall | (sb.d_eret & epc_hit));
  assign issue     = sb.d_valid & ~stall & ~sb.flush;
  assign md_start  = issue & ((sb.d_md_op == 2'd1) || (sb.d_md_op == 2'd2));
  assign load0     = issue & (sb.d_wr_en | sb.d_mtc0_epc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NSTAGE; i++)
        ent[i] <= '0;
      md_mark   <= 1'b0;
      md_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      for (int unsigned i = 1; i < NSTAGE; i++) begin
        ent[i].v    <= ent[i-1].v & ~sb.flush;
        ent[i].addr <= ent[i-1].addr;
        ent[i].tnew <= (ent[i-1].tnew == 2'd0) ? 2'd0 : ent[i-1].tnew - 2'd1;
        ent[i].epc  <= ent[i-1].epc;
      end
      if (load0)
        ent[0] <= '{v: 1'b1, addr: (sb.d_wr_en ? sb.d_wr_addr : 5'd0),
                    tnew: sb.d_tnew, epc: sb.d_mtc0_epc};
      else
        ent[0] <= '0;

      // MDU busy period runs on regardless of flush; only reset aborts it.
      md_mark <= md_start;
      if (md_start)
        md_cnt <= (sb.d_md_op == 2'd1) ? MD_W'(MULT_LAT) : MD_W'(DIV_LAT);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - 1'b1;

      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign sb.stall      = stall;
  assign sb.pc_en      = ~stall;
  assign sb.ifid_en    = ~stall;
  assign sb.idex_clr   = stall | sb.flush;
  assign sb.fwd_rs_sel = fwd_rs;
  assign sb.fwd_rt_sel = fwd_rt;
  assign sb.md_busy    = (md_cnt != '0);
  assign sb.stall_cnt  = stall_cnt;
endmodule
